// File: rtl/exe_buffer_stack.sv
// Word-granular LIFO save buffer: pushes shift contents toward the MSB end and pops shift toward the LSB end.
// It also provides random indexed reads, sticky overflow/underflow flags, and a flush that keeps the contents.
module exe_buffer_stack #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 29,
  parameter int CNT_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      exe_reset,
  input  logic                      push_dword,
  input  logic                      push_word,
  input  logic [2*WORD_W-1:0]       push_data,
  input  logic                      pop_word,
  input  logic                      rd_do,
  input  logic [CNT_W-1:0]          rd_index,
  output logic [DEPTH*WORD_W-1:0]   buf_shifted,
  output logic [CNT_W-1:0]          buf_count,
  output logic                      buf_empty,
  output logic                      buf_full,
  output logic                      buf_overflow,
  output logic                      buf_underflow,
  output logic [WORD_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      rd_err
);

  localparam int BW = DEPTH * WORD_W;
  localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(DEPTH);

  logic            any_push;
  logic [1:0]      push_n;
  logic            do_pop;
  logic            underflow_evt;
  logic            overflow_evt;
  logic [BW-1:0]   after_pop;
  logic [BW-1:0]   buf_nxt;
  logic [CNT_W:0]  cnt_sum;
  logic [CNT_W-1:0] cnt_nxt;
  logic            rd_hit;
  logic [WORD_W-1:0] rd_word;

  assign buf_empty = (buf_count == '0);
  assign buf_full  = (buf_count == DEPTH_X[CNT_W-1:0]);

  // A pop on an empty buffer is a no-op; any push in the same cycle still lands.
  always_comb begin
    any_push      = push_dword | push_word;
    push_n        = push_dword ? 2'd2 : (push_word ? 2'd1 : 2'd0);
    do_pop        = pop_word && (buf_count != '0);
    underflow_evt = pop_word && (buf_count == '0) && !any_push;

    after_pop = do_pop ? (buf_shifted >> WORD_W) : buf_shifted;
    buf_nxt   = after_pop;
    if (push_dword)
      buf_nxt = {after_pop[BW-2*WORD_W-1:0], push_data};
    else if (push_word)
      buf_nxt = {after_pop[BW-WORD_W-1:0], push_data[WORD_W-1:0]};

    cnt_sum      = {1'b0, buf_count} - (CNT_W+1)'(do_pop) + (CNT_W+1)'(push_n);
    overflow_evt = (cnt_sum > DEPTH_X);
    cnt_nxt      = overflow_evt ? DEPTH_X[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  // Reads see the contents as they were before this cycle's push/pop.
  always_comb begin
    rd_hit  = (rd_index < buf_count);
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_index == CNT_W'(i))
        rd_word = buf_shifted[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_shifted   <= '0;
      buf_count     <= '0;
      buf_overflow  <= 1'b0;
      buf_underflow <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      rd_err        <= 1'b0;
    end else if (exe_reset) begin
      buf_count     <= '0;
      buf_overflow  <= 1'b0;
      buf_underflow <= 1'b0;
      rd_valid      <= 1'b0;
      rd_err        <= 1'b0;
    end else begin
      buf_shifted   <= buf_nxt;
      buf_count     <= cnt_nxt;
      buf_overflow  <= buf_overflow | overflow_evt;
      buf_underflow <= buf_underflow | underflow_evt;
      rd_valid      <= rd_do & rd_hit;
      rd_err        <= rd_do & ~rd_hit;
      if (rd_do)
        rd_data <= rd_hit ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_exe_buffer_stack.sv
// Bench for exe_buffer_stack: directed vector table, corner-case sequences, and randomized traffic
// checked against a word-array model of the buffer.
module tb_exe_buffer_stack;

  localparam int WORD_W = 16;
  localparam int DEPTH  = 29;
  localparam int CNT_W  = 5;
  localparam int BW     = DEPTH * WORD_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              exe_reset, push_dword, push_word, pop_word, rd_do;
  logic [31:0]       push_data;
  logic [CNT_W-1:0]  rd_index;
  logic [BW-1:0]     buf_shifted;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty, buf_full, buf_overflow, buf_underflow;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid, rd_err;

  exe_buffer_stack #(.WORD_W(WORD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .exe_reset(exe_reset),
    .push_dword(push_dword), .push_word(push_word), .push_data(push_data),
    .pop_word(pop_word), .rd_do(rd_do), .rd_index(rd_index),
    .buf_shifted(buf_shifted), .buf_count(buf_count),
    .buf_empty(buf_empty), .buf_full(buf_full),
    .buf_overflow(buf_overflow), .buf_underflow(buf_underflow),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word array, index 0 = newest.
  logic [WORD_W-1:0] m_buf[DEPTH];
  int                m_cnt;
  bit                m_ovf, m_udf, m_rv, m_re;
  logic [WORD_W-1:0] m_rd;

  function void model_reset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    m_cnt = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_re = 0; m_rd = '0;
  endfunction

  function void model_insert(input logic [WORD_W-1:0] w);
    for (int i = DEPTH-1; i > 0; i--) m_buf[i] = m_buf[i-1];
    m_buf[0] = w;
  endfunction

  function void model_step(input bit ex, pd, pw, input logic [31:0] data,
                           input bit pop, rd, input logic [CNT_W-1:0] idx);
    int n;
    if (ex) begin
      m_cnt = 0; m_ovf = 0; m_udf = 0; m_rv = 0; m_re = 0;
      return;
    end
    m_rv = 0; m_re = 0;
    if (rd) begin
      if (int'(idx) < m_cnt) begin m_rd = m_buf[idx]; m_rv = 1; end
      else begin m_rd = '0; m_re = 1; end
    end
    if (pop) begin
      if (m_cnt > 0) begin
        for (int i = 0; i < DEPTH-1; i++) m_buf[i] = m_buf[i+1];
        m_buf[DEPTH-1] = '0;
        m_cnt--;
      end else if (!(pd || pw)) begin
        m_udf = 1;
      end
    end
    n = 0;
    if (pd) begin
      model_insert(data[31:16]); model_insert(data[15:0]); n = 2;
    end else if (pw) begin
      model_insert(data[15:0]); n = 1;
    end
    m_cnt += n;
    if (m_cnt > DEPTH) begin m_cnt = DEPTH; m_ovf = 1; end
  endfunction

  function logic [BW-1:0] model_packed();
    logic [BW-1:0] p;
    for (int i = 0; i < DEPTH; i++) p[i*WORD_W +: WORD_W] = m_buf[i];
    return p;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic check_all();
    check("count",     BW'(buf_count),     BW'(m_cnt));
    check("empty",     BW'(buf_empty),     BW'(m_cnt == 0));
    check("full",      BW'(buf_full),      BW'(m_cnt == DEPTH));
    check("overflow",  BW'(buf_overflow),  BW'(m_ovf));
    check("underflow", BW'(buf_underflow), BW'(m_udf));
    check("rd_valid",  BW'(rd_valid),      BW'(m_rv));
    check("rd_err",    BW'(rd_err),        BW'(m_re));
    check("rd_data",   BW'(rd_data),       BW'(m_rd));
    check("contents",  buf_shifted,        model_packed());
  endtask

  task automatic idle_inputs();
    exe_reset = 0; push_dword = 0; push_word = 0; pop_word = 0;
    rd_do = 0; push_data = '0; rd_index = '0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check 1 ns after it.
  task automatic step(input bit ex, pd, pw, input logic [31:0] data,
                      input bit pop, rd, input logic [CNT_W-1:0] idx);
    exe_reset = ex; push_dword = pd; push_word = pw; push_data = data;
    pop_word = pop; rd_do = rd; rd_index = idx;
    @(posedge clk);
    model_step(ex, pd, pw, data, pop, rd, idx);
    #1;
    idle_inputs();
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    #2;
    rst_n = 1;
  endtask

  typedef struct {
    bit ex, pd, pw, pop, rd;
    logic [31:0] data;
    logic [CNT_W-1:0] idx;
    int exp_cnt;
    logic [WORD_W-1:0] exp_w0;
    bit exp_ovf, exp_udf, exp_rv, exp_re;
    logic [WORD_W-1:0] exp_rd;
  } vec_t;

  vec_t tbl[12];
  logic [BW-1:0] snap;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ex pd pw pop rd data          idx cnt w0       ovf udf rv re rd
    tbl[0]  = '{0, 1, 0, 0, 0, 32'hAAAA_BBBB, 0, 2, 16'hBBBB, 0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{0, 0, 1, 0, 0, 32'h0000_1234, 0, 3, 16'h1234, 0, 0, 0, 0, 16'h0000};
    tbl[2]  = '{0, 1, 1, 0, 0, 32'h5678_9ABC, 0, 5, 16'h9ABC, 0, 0, 0, 0, 16'h0000};
    tbl[3]  = '{0, 0, 0, 1, 0, 32'h0,         0, 4, 16'h5678, 0, 0, 0, 0, 16'h0000};
    tbl[4]  = '{0, 0, 0, 0, 1, 32'h0,         3, 4, 16'h5678, 0, 0, 1, 0, 16'hAAAA};
    tbl[5]  = '{0, 0, 0, 0, 1, 32'h0,         4, 4, 16'h5678, 0, 0, 0, 1, 16'h0000};
    tbl[6]  = '{0, 0, 1, 1, 1, 32'h0000_5555, 0, 4, 16'h5555, 0, 0, 1, 0, 16'h5678};
    tbl[7]  = '{1, 0, 1, 0, 0, 32'h0000_7777, 0, 0, 16'h5555, 0, 0, 0, 0, 16'h5678};
    tbl[8]  = '{0, 0, 0, 1, 0, 32'h0,         0, 0, 16'h5555, 0, 1, 0, 0, 16'h5678};
    tbl[9]  = '{0, 0, 0, 1, 0, 32'h0,         0, 0, 16'h5555, 0, 1, 0, 0, 16'h5678};
    tbl[10] = '{0, 0, 1, 0, 0, 32'h0000_0001, 0, 1, 16'h0001, 0, 1, 0, 0, 16'h5678};
    tbl[11] = '{1, 0, 0, 0, 0, 32'h0,         0, 0, 16'h0001, 0, 0, 0, 0, 16'h5678};

    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    foreach (tbl[k]) begin
      step(tbl[k].ex, tbl[k].pd, tbl[k].pw, tbl[k].data, tbl[k].pop, tbl[k].rd, tbl[k].idx);
      check($sformatf("tbl%0d_cnt", k), BW'(buf_count),     BW'(tbl[k].exp_cnt));
      check($sformatf("tbl%0d_w0", k),  BW'(buf_shifted[WORD_W-1:0]), BW'(tbl[k].exp_w0));
      check($sformatf("tbl%0d_ovf", k), BW'(buf_overflow),  BW'(tbl[k].exp_ovf));
      check($sformatf("tbl%0d_udf", k), BW'(buf_underflow), BW'(tbl[k].exp_udf));
      check($sformatf("tbl%0d_rv", k),  BW'(rd_valid),      BW'(tbl[k].exp_rv));
      check($sformatf("tbl%0d_re", k),  BW'(rd_err),        BW'(tbl[k].exp_re));
      check($sformatf("tbl%0d_rd", k),  BW'(rd_data),       BW'(tbl[k].exp_rd));
    end

    // Dword then word: low 48 bits read as one concatenated value.
    do_reset();
    step(0, 1, 0, 32'hAAAA_BBBB, 0, 0, 0);
    step(0, 0, 1, 32'h0000_1234, 0, 0, 0);
    check("seq_a_cnt",   BW'(buf_count),        BW'(3));
    check("seq_a_low48", BW'(buf_shifted[47:0]), BW'(48'hAAAA_BBBB_1234));

    // Fill past capacity with dwords.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 0, {16'(16'hA000 + i), 16'(16'hB000 + i)}, 0, 0, 0);
      if (i == 13) begin
        check("seq_b_cnt28", BW'(buf_count),    BW'(28));
        check("seq_b_noovf", BW'(buf_overflow), BW'(0));
      end
    end
    check("seq_b_cnt",    BW'(buf_count),    BW'(29));
    check("seq_b_full",   BW'(buf_full),     BW'(1));
    check("seq_b_ovf",    BW'(buf_overflow), BW'(1));
    check("seq_b_newest", BW'(buf_shifted[WORD_W-1:0]), BW'(16'hB00E));
    check("seq_b_oldest", BW'(buf_shifted[BW-1 -: WORD_W]), BW'(16'hB000));

    // Drain to 5 with overflow still set, then flush together with a push.
    for (int i = 0; i < 24; i++) step(0, 0, 0, 32'h0, 1, 0, 0);
    check("seq_e_cnt5", BW'(buf_count),    BW'(5));
    check("seq_e_ovf",  BW'(buf_overflow), BW'(1));
    snap = model_packed();
    step(1, 0, 1, 32'h0000_DEAD, 0, 0, 0);
    check("seq_e_cnt0",     BW'(buf_count),     BW'(0));
    check("seq_e_ovf_clr",  BW'(buf_overflow),  BW'(0));
    check("seq_e_udf_clr",  BW'(buf_underflow), BW'(0));
    check("seq_e_contents", buf_shifted,        snap);

    // Pop and push together at count 2.
    step(0, 0, 1, 32'h0000_0001, 0, 0, 0);
    step(0, 0, 1, 32'h0000_0002, 0, 0, 0);
    step(0, 0, 1, 32'h0000_5555, 1, 0, 0);
    check("seq_c_cnt", BW'(buf_count), BW'(2));
    check("seq_c_w0",  BW'(buf_shifted[15:0]),  BW'(16'h5555));
    check("seq_c_w1",  BW'(buf_shifted[31:16]), BW'(16'h0001));

    // In-range and out-of-range reads.
    step(1, 0, 0, 32'h0, 0, 0, 0);
    step(0, 0, 1, 32'h0000_1111, 0, 0, 0);
    step(0, 0, 1, 32'h0000_2222, 0, 0, 0);
    step(0, 0, 1, 32'h0000_3333, 0, 0, 0);
    step(0, 0, 0, 32'h0, 0, 1, 2);
    check("seq_d_rd",  BW'(rd_data),  BW'(16'h1111));
    check("seq_d_rv",  BW'(rd_valid), BW'(1));
    step(0, 0, 0, 32'h0, 0, 1, 3);
    check("seq_d_err", BW'(rd_err),   BW'(1));
    check("seq_d_rv0", BW'(rd_valid), BW'(0));
    check("seq_d_rd0", BW'(rd_data),  BW'(0));
    step(0, 0, 0, 32'h0, 0, 0, 0);
    check("seq_d_idle_rv", BW'(rd_valid), BW'(0));
    check("seq_d_idle_re", BW'(rd_err),   BW'(0));

    // Asynchronous reset between edges while a push is pending.
    step(0, 0, 0, 32'h0, 0, 1, 0);
    push_dword = 1; push_data = 32'hCAFE_F00D;
    #3;
    rst_n = 0;
    model_reset();
    #1;
    check("seq_f_buf",   buf_shifted,          BW'(0));
    check("seq_f_cnt",   BW'(buf_count),       BW'(0));
    check("seq_f_empty", BW'(buf_empty),       BW'(1));
    check("seq_f_flags", BW'({buf_overflow, buf_underflow}), BW'(0));
    check("seq_f_rd",    BW'({rd_data, rd_valid, rd_err}),   BW'(0));
    @(posedge clk);
    #1;
    check("seq_f_hold_buf", buf_shifted,    BW'(0));
    check("seq_f_hold_cnt", BW'(buf_count), BW'(0));
    #2;
    idle_inputs();
    rst_n = 1;
    step(0, 0, 0, 32'h0, 0, 0, 0);

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit bias, ex, pd, pw, pop, rd;
      bias = ((n / 150) % 2) == 0;
      pd  = $urandom_range(0, 99) < (bias ? 25 : 8);
      pw  = $urandom_range(0, 99) < (bias ? 40 : 15);
      pop = $urandom_range(0, 99) < (bias ? 15 : 60);
      ex  = $urandom_range(0, 199) == 0;
      rd  = $urandom_range(0, 1) == 1;
      step(ex, pd, pw, $urandom, pop, rd, CNT_W'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
